// File: rtl/alu_pkg.sv
// Shared types for the ALU command queue: opcode, queued command record and FSM state.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef logic [2:0] alu_op_t;

  typedef struct packed {
    alu_op_t                op;
    logic [ALU_WIDTH-1:0]   a;
    logic [ALU_WIDTH-1:0]   b;
    logic                   cin;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } aq_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Circular command buffer of DEPTH alu_cmd_t entries; head entry is presented combinationally.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  alu_cmd_t                   wdata,
  input  logic                       pop,
  output alu_cmd_t                   rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  alu_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers are exactly AW bits wide so they wrap without explicit compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_queue.sv
// Buffers ALU commands, drives them one at a time onto a combinational ALU and registers the result.
// Optional saturating completion counters are enabled with ALU_CMD_QUEUE_STATS_EN.
module alu_cmd_queue
  import alu_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [WIDTH-1:0]         cmd_a,
  input  logic [WIDTH-1:0]         cmd_b,
  input  logic                     cmd_cin,
  output logic [2:0]               alu_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic                     alu_cin,
  input  logic [WIDTH-1:0]         alu_w,
  input  logic                     alu_zer,
  input  logic                     alu_neg,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_w,
  output logic                     res_zer,
  output logic                     res_neg,
  output logic [2:0]               res_op,
`ifdef ALU_CMD_QUEUE_STATS_EN
  output logic [15:0]              stat_done,
  output logic [15:0]              stat_zero,
`endif
  output aq_state_t                dbg_state,
  output logic [$clog2(DEPTH):0]   dbg_count
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // holds its payload until that edge, and ready never depends on valid.

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  aq_state_t   state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic        pop;
  logic        res_load;
  logic        res_done;

  alu_cmd_t    push_cmd;
  alu_cmd_t    head_cmd;
  logic        fifo_full;
  logic        fifo_empty;

  always_comb begin
    push_cmd     = '0;
    push_cmd.op  = cmd_op;
    push_cmd.a   = cmd_a;
    push_cmd.b   = cmd_b;
    push_cmd.cin = cmd_cin;
  end

  // cmd_ready comes from the registered count, so a same-edge pop never gates a push.
  assign cmd_ready = !fifo_full;
  assign dbg_state = state_q;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && cmd_ready),
    .wdata (push_cmd),
    .pop   (pop),
    .rdata (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (dbg_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    pop      = 1'b0;
    res_load = 1'b0;
    res_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          settle_d = '0;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          res_load = 1'b1;
          state_d  = RESP;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      RESP: begin
        if (res_valid && res_ready) begin
          res_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU inputs only move on a pop, keeping them steady through DRIVE and RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op  <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_cin <= 1'b0;
    end else if (pop) begin
      alu_op  <= head_cmd.op;
      alu_a   <= head_cmd.a;
      alu_b   <= head_cmd.b;
      alu_cin <= head_cmd.cin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_w     <= '0;
      res_zer   <= 1'b0;
      res_neg   <= 1'b0;
      res_op    <= '0;
    end else if (res_load) begin
      res_valid <= 1'b1;
      res_w     <= alu_w;
      res_zer   <= alu_zer;
      res_neg   <= alu_neg;
      res_op    <= alu_op;
    end else if (res_done) begin
      res_valid <= 1'b0;
    end
  end

`ifdef ALU_CMD_QUEUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_done <= '0;
      stat_zero <= '0;
    end else if (res_done) begin
      if (stat_done != 16'hFFFF) stat_done <= stat_done + 1'b1;
      if (res_zer && (stat_zero != 16'hFFFF)) stat_zero <= stat_zero + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed bench for alu_cmd_queue with a behavioural ALU attached and an in-order result scoreboard.
// Define ALU_CMD_QUEUE_STATS_EN to also cover the completion counters.
module tb_alu_cmd_queue;
  import alu_pkg::*;

  localparam int W  = 16;
  localparam int EW = 3 + W + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [W-1:0]  cmd_a;
  logic [W-1:0]  cmd_b;
  logic          cmd_cin;
  logic [2:0]    alu_op;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic          alu_cin;
  logic [W-1:0]  alu_w;
  logic          alu_zer;
  logic          alu_neg;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_w;
  logic          res_zer;
  logic          res_neg;
  logic [2:0]    res_op;
`ifdef ALU_CMD_QUEUE_STATS_EN
  logic [15:0]   stat_done;
  logic [15:0]   stat_zero;
`endif
  aq_state_t     dbg_state;
  logic [2:0]    dbg_count;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int n_zero   = 0;
  int cyc      = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  alu_cmd_queue dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_cin   (cmd_cin),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cin   (alu_cin),
    .alu_w     (alu_w),
    .alu_zer   (alu_zer),
    .alu_neg   (alu_neg),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_w     (res_w),
    .res_zer   (res_zer),
    .res_neg   (res_neg),
    .res_op    (res_op),
`ifdef ALU_CMD_QUEUE_STATS_EN
    .stat_done (stat_done),
    .stat_zero (stat_zero),
`endif
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  // ---------------- behavioural ALU ----------------
  function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic cin);
    case (op)
      3'd0:    return a + b + W'(cin);
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a;
      3'd6:    return ~a;
      default: return b;
    endcase
  endfunction

  always_comb begin
    alu_w   = alu_fn(alu_op, alu_a, alu_b, alu_cin);
    alu_zer = (alu_w == '0);
    alu_neg = alu_w[W-1];
  end

  function automatic logic [EW-1:0] exp_of(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic cin);
    logic [W-1:0] w;
    w = alu_fn(op, a, b, cin);
    return {op, w, (w == '0), w[W-1]};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: results must leave in push order, one per handshake.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_result", 32'(res_w), 32'hDEAD_BEEF);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("result", 32'({res_op, res_w, res_zer, res_neg}), 32'(e));
        n_done++;
        if (e[1]) n_zero++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin);
    int t;
    t = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("push_wait", 32'(t < 200), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    exp_q.push_back(exp_of(op, a, b, cin));
  endtask

  task automatic wait_res();
    int t;
    t = 0;
    while (!res_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("res_wait", 32'(t < 100), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || res_valid) && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_wait", 32'(t < budget), 32'd1);
  endtask

  task automatic wait_state(input aq_state_t s);
    int t;
    t = 0;
    while (dbg_state != s && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("state_wait", 32'(t < 100), 32'd1);
  endtask

  task automatic check_reset_values();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_alu_op",    32'(alu_op),    32'd0);
    check("rst_alu_a",     32'(alu_a),     32'd0);
    check("rst_alu_b",     32'(alu_b),     32'd0);
    check("rst_alu_cin",   32'(alu_cin),   32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_w",     32'(res_w),     32'd0);
    check("rst_res_zer",   32'(res_zer),   32'd0);
    check("rst_res_neg",   32'(res_neg),   32'd0);
    check("rst_res_op",    32'(res_op),    32'd0);
    check("rst_count",     32'(dbg_count), 32'd0);
    check("rst_state",     32'(dbg_state), 32'(IDLE));
`ifdef ALU_CMD_QUEUE_STATS_EN
    check("rst_stat_done", 32'(stat_done), 32'd0);
    check("rst_stat_zero", 32'(stat_zero), 32'd0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    int start;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_cin = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_values();

    // Single command: accepted at E0, popped at E1, result valid at E3.
    push(3'd0, 16'd5, 16'd7, 1'b0);
    check("e0_res_valid", 32'(res_valid), 32'd0);
    check("e0_state",     32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    check("e1_state",     32'(dbg_state), 32'(DRIVE));
    check("e1_alu_a",     32'(alu_a),     32'd5);
    check("e1_alu_b",     32'(alu_b),     32'd7);
    check("e1_res_valid", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    check("e2_res_valid", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    check("e3_res_valid", 32'(res_valid), 32'd1);
    check("e3_res_w",     32'(res_w),     32'd12);
    check("e3_res_op",    32'(res_op),    32'd0);
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("e4_res_valid", 32'(res_valid), 32'd0);
    res_ready = 1'b0;

    // Fill to full: first command parks in RESP, four more fill the FIFO.
    push(3'd2, 16'hF0F0, 16'hFF00, 1'b0);
    wait_state(RESP);
    push(3'd3, 16'h000F, 16'h00F0, 1'b0);
    check("fill1_ready", 32'(cmd_ready), 32'd1);
    push(3'd4, 16'hFFFF, 16'hFFFF, 1'b0);
    check("fill2_ready", 32'(cmd_ready), 32'd1);
    push(3'd6, 16'h0000, 16'h0000, 1'b0);
    check("fill3_ready", 32'(cmd_ready), 32'd1);
    push(3'd7, 16'h0000, 16'h1234, 1'b0);
    check("fill4_ready", 32'(cmd_ready), 32'd0);
    check("fill4_count", 32'(dbg_count), 32'd4);
    cmd_op = 3'd0; cmd_a = 16'd1; cmd_b = 16'd1; cmd_cin = 1'b0;
    cmd_valid = 1'b1;
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (cmd_ready) bad++;
    end
    cmd_valid = 1'b0;
    check("full_blocks", 32'(bad), 32'd0);
    check("full_count",  32'(dbg_count), 32'd4);
    check("full_alu_a",  32'(alu_a), 32'hF0F0);
    res_ready = 1'b1;
    wait_drain(100);
    repeat (8) @(posedge clk);
    #1;
    check("drain_ready", 32'(cmd_ready), 32'd1);
    check("drain_count", 32'(dbg_count), 32'd0);

    // Wrap-around with res_ready held high; ten commands span two pointer wraps.
    start = cyc;
    for (int i = 0; i < 10; i++)
      push(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)),
           16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
    wait_drain(200);
    check("throughput", 32'((cyc - start) <= 44), 32'd1);
    repeat (4) @(posedge clk);
    #1;

    // Flags straight from the ALU.
    res_ready = 1'b0;
    push(3'd5, 16'h8000, 16'h0000, 1'b0);
    wait_res();
    check("neg_flag",  32'(res_neg), 32'd1);
    check("neg_zer",   32'(res_zer), 32'd0);
    check("neg_w",     32'(res_w),   32'h8000);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    push(3'd0, 16'h0000, 16'h0000, 1'b0);
    wait_res();
    check("zer_flag",  32'(res_zer), 32'd1);
    check("zer_neg",   32'(res_neg), 32'd0);
    res_ready = 1'b1;
    wait_drain(50);
    res_ready = 1'b0;

    // Backpressure: 100-30 held in RESP with one more queued behind it.
    push(3'd1, 16'd100, 16'd30, 1'b0);
    push(3'd0, 16'd1, 16'd2, 1'b0);
    wait_res();
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (res_w !== 16'd70 || res_op !== 3'd1 || res_valid !== 1'b1 ||
          alu_a !== 16'd100 || alu_b !== 16'd30 || alu_op !== 3'd1 ||
          dbg_state !== RESP || dbg_count !== 3'd1) bad++;
    end
    check("backpressure_hold", 32'(bad), 32'd0);
    res_ready = 1'b1;
    wait_drain(50);
`ifdef ALU_CMD_QUEUE_STATS_EN
    check("stat_done", 32'(stat_done), 32'(n_done));
    check("stat_zero", 32'(stat_zero), 32'(n_zero));
`endif
    res_ready = 1'b0;

    // Reset while in DRIVE with two commands queued.
    push(3'd0, 16'd3, 16'd4, 1'b0);
    push(3'd2, 16'hAAAA, 16'h5555, 1'b0);
    push(3'd3, 16'h1111, 16'h2222, 1'b0);
    check("mid_state", 32'(dbg_state), 32'(DRIVE));
    check("mid_count", 32'(dbg_count), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_values();
    rst = 1'b0;
    exp_q.delete();
    res_ready = 1'b1;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (res_valid) bad++;
    end
    check("no_stale_result", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
